// File: rtl/mig_ui_responder_if.sv
// mig_ui_responder_if
//   Bundles the MIG 7-series application-side command, write-data and read-data
//   signals so an initiator and the BRAM responder can be wired with a single port.
//   Ports (signals):
//     app_addr/app_cmd/app_en          command from initiator, app_rdy accept back
//     app_wdf_data/mask/wren/end       write data from initiator, app_wdf_rdy back
//     app_rd_data/valid/end            read data returned by the responder
//   Modports: master = initiator (sound-engine reader/writer), slave = memory side.
interface mig_ui_responder_if #(
    parameter int ADDR_WIDTH = 29,
    parameter int DATA_WIDTH = 256,
    parameter int MASK_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] app_addr;
    logic [2:0]            app_cmd;
    logic                  app_en;
    logic                  app_rdy;
    logic [DATA_WIDTH-1:0] app_wdf_data;
    logic [MASK_WIDTH-1:0] app_wdf_mask;
    logic                  app_wdf_wren;
    logic                  app_wdf_end;
    logic                  app_wdf_rdy;
    logic [DATA_WIDTH-1:0] app_rd_data;
    logic                  app_rd_data_valid;
    logic                  app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
    );
endinterface

// File: rtl/mig_ui_responder.sv
// mig_ui_responder
//   BRAM-backed stand-in for the MIG 7-series user interface. Accepts commands and
//   write data in any relative order, pairs them in FIFO order, executes one command
//   per cycle and returns read data a fixed RD_LATENCY cycles after execution.
//   Ports:
//     ui_clk, ui_clk_sync_rst   clock, asynchronous active-high reset
//     init_calib_complete       high once the calibration delay has elapsed
//     cmd_err                   sticky flag: an illegal app_cmd was accepted
//     app                       application interface (slave side)
module mig_ui_responder #(
    parameter int ADDR_WIDTH   = 29,
    parameter int DATA_WIDTH   = 256,
    parameter int MASK_WIDTH   = 32,
    parameter int DEPTH_LOG2   = 6,
    parameter int RD_LATENCY   = 4,
    parameter int CALIB_CYCLES = 16,
    parameter int STALL_EVERY  = 0,
    parameter int STALL_LEN    = 2
) (
    input  logic ui_clk,
    input  logic ui_clk_sync_rst,
    output logic init_calib_complete,
    output logic cmd_err,
    mig_ui_responder_if.slave app
);
    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);
    localparam int STE_W = $clog2(STALL_EVERY + 2);
    localparam int STL_W = $clog2(STALL_LEN + 2);

    typedef enum logic [1:0] {
        ST_CALIB = 2'd0,
        ST_READY = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t           state_r;
    logic [CAL_W-1:0] calib_cnt_r;
    logic [STE_W-1:0] acc_cnt_r;
    logic [STL_W-1:0] stall_cnt_r;
    logic             app_rdy_r;
    logic             wdf_rdy_r;
    logic             calib_r;
    logic             cmd_err_r;

    // Command queue keeps only the read/write flag and the beat index.
    logic                  cq_rd_r  [4];
    logic [DEPTH_LOG2-1:0] cq_idx_r [4];
    logic [1:0]            cq_wp_r, cq_rp_r;
    logic [2:0]            cq_cnt_r;
    logic [DATA_WIDTH-1:0] wq_data_r [4];
    logic [MASK_WIDTH-1:0] wq_mask_r [4];
    logic [1:0]            wq_wp_r, wq_rp_r;
    logic [2:0]            wq_cnt_r;

    logic [DATA_WIDTH-1:0] mem_r [2**DEPTH_LOG2];
    logic                  vld_r [RD_LATENCY];
    logic [DATA_WIDTH-1:0] dat_r [RD_LATENCY];

    logic                  cmd_acc_s, cmd_legal_s, cq_push_s, wdf_acc_s;
    logic                  head_rd_s, exec_rd_s, exec_wr_s, cq_pop_s;
    logic [DEPTH_LOG2-1:0] head_idx_s;
    logic [2:0]            cq_cnt_nxt_s, wq_cnt_nxt_s;
    logic                  unused_s;

    // Handshake decode and execution selection for the queue heads.
    always_comb begin
        cmd_acc_s    = app.app_en & app_rdy_r;
        cmd_legal_s  = (app.app_cmd == 3'b000) | (app.app_cmd == 3'b001);
        cq_push_s    = cmd_acc_s & cmd_legal_s;
        wdf_acc_s    = app.app_wdf_wren & wdf_rdy_r;
        head_rd_s    = cq_rd_r[cq_rp_r];
        head_idx_s   = cq_idx_r[cq_rp_r];
        exec_rd_s    = (cq_cnt_r != 3'd0) & head_rd_s;
        // A head write without data stalls everything behind it, keeping read-after-write order.
        exec_wr_s    = (cq_cnt_r != 3'd0) & ~head_rd_s & (wq_cnt_r != 3'd0);
        cq_pop_s     = exec_rd_s | exec_wr_s;
        cq_cnt_nxt_s = cq_cnt_r + {2'b00, cq_push_s} - {2'b00, cq_pop_s};
        wq_cnt_nxt_s = wq_cnt_r + {2'b00, wdf_acc_s} - {2'b00, exec_wr_s};
    end

    // Address low bits and upper alias bits are intentionally ignored; wdf_end is not checked.
    assign unused_s = ^{app.app_addr, app.app_wdf_end};

    // Calibration / throttle FSM; ready flags are computed from next-cycle queue occupancy.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            state_r     <= ST_CALIB;
            calib_cnt_r <= {CAL_W{1'b0}};
            acc_cnt_r   <= {STE_W{1'b0}};
            stall_cnt_r <= {STL_W{1'b0}};
            app_rdy_r   <= 1'b0;
            wdf_rdy_r   <= 1'b0;
            calib_r     <= 1'b0;
            cmd_err_r   <= 1'b0;
        end else begin
            if (cmd_acc_s && !cmd_legal_s) begin
                cmd_err_r <= 1'b1;
            end
            case (state_r)
                ST_CALIB: begin
                    if (calib_cnt_r == CAL_W'(CALIB_CYCLES - 1)) begin
                        state_r   <= ST_READY;
                        calib_r   <= 1'b1;
                        app_rdy_r <= (cq_cnt_nxt_s != 3'd4);
                        wdf_rdy_r <= (wq_cnt_nxt_s != 3'd4);
                    end else begin
                        calib_cnt_r <= calib_cnt_r + CAL_W'(1);
                        app_rdy_r   <= 1'b0;
                        wdf_rdy_r   <= 1'b0;
                    end
                end
                ST_READY: begin
                    wdf_rdy_r <= (wq_cnt_nxt_s != 3'd4);
                    if (STALL_EVERY != 0 && cmd_acc_s && acc_cnt_r == STE_W'(STALL_EVERY - 1)) begin
                        state_r     <= ST_STALL;
                        acc_cnt_r   <= {STE_W{1'b0}};
                        stall_cnt_r <= {STL_W{1'b0}};
                        app_rdy_r   <= 1'b0;
                    end else begin
                        if (cmd_acc_s) begin
                            acc_cnt_r <= acc_cnt_r + STE_W'(1);
                        end
                        app_rdy_r <= (cq_cnt_nxt_s != 3'd4);
                    end
                end
                ST_STALL: begin
                    wdf_rdy_r <= (wq_cnt_nxt_s != 3'd4);
                    if (stall_cnt_r == STL_W'(STALL_LEN - 1)) begin
                        state_r   <= ST_READY;
                        app_rdy_r <= (cq_cnt_nxt_s != 3'd4);
                    end else begin
                        stall_cnt_r <= stall_cnt_r + STL_W'(1);
                        app_rdy_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_CALIB;
                    app_rdy_r <= 1'b0;
                    wdf_rdy_r <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy counters.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            cq_wp_r  <= 2'd0;
            cq_rp_r  <= 2'd0;
            cq_cnt_r <= 3'd0;
            wq_wp_r  <= 2'd0;
            wq_rp_r  <= 2'd0;
            wq_cnt_r <= 3'd0;
        end else begin
            if (cq_push_s) cq_wp_r <= cq_wp_r + 2'd1;
            if (cq_pop_s)  cq_rp_r <= cq_rp_r + 2'd1;
            if (wdf_acc_s) wq_wp_r <= wq_wp_r + 2'd1;
            if (exec_wr_s) wq_rp_r <= wq_rp_r + 2'd1;
            cq_cnt_r <= cq_cnt_nxt_s;
            wq_cnt_r <= wq_cnt_nxt_s;
        end
    end

    // Queue entry storage; validity is tracked by the pointers alone.
    always_ff @(posedge ui_clk) begin
        if (cq_push_s) begin
            cq_rd_r[cq_wp_r]  <= app.app_cmd[0];
            cq_idx_r[cq_wp_r] <= app.app_addr[3 +: DEPTH_LOG2];
        end
        if (wdf_acc_s) begin
            wq_data_r[wq_wp_r] <= app.app_wdf_data;
            wq_mask_r[wq_wp_r] <= app.app_wdf_mask;
        end
    end

    // Beat memory with byte enables; mask bit set means the byte is kept.
    always_ff @(posedge ui_clk) begin
        if (exec_wr_s) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (!wq_mask_r[wq_rp_r][b]) begin
                    mem_r[head_idx_s][8*b +: 8] <= wq_data_r[wq_rp_r][8*b +: 8];
                end
            end
        end
    end

    // Read latency pipe; a data stage only advances with a valid so the output holds its last beat.
    always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
        if (ui_clk_sync_rst) begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                vld_r[k] <= 1'b0;
                dat_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < RD_LATENCY; k++) begin
                if (k == 0) begin
                    vld_r[0] <= exec_rd_s;
                    if (exec_rd_s) dat_r[0] <= mem_r[head_idx_s];
                end else begin
                    vld_r[k] <= vld_r[k-1];
                    if (vld_r[k-1]) dat_r[k] <= dat_r[k-1];
                end
            end
        end
    end

    assign app.app_rdy           = app_rdy_r;
    assign app.app_wdf_rdy       = wdf_rdy_r;
    assign app.app_rd_data       = dat_r[RD_LATENCY-1];
    assign app.app_rd_data_valid = vld_r[RD_LATENCY-1];
    assign app.app_rd_data_end   = vld_r[RD_LATENCY-1];
    assign init_calib_complete   = calib_r;
    assign cmd_err               = cmd_err_r;
endmodule

// File: tb/tb_mig_ui_responder.sv
// tb_mig_ui_responder
//   Directed bench for mig_ui_responder: calibration timing, write/read ordering and
//   latency, byte masks, address aliasing, throttle windows, write-before-data pairing,
//   reset flush and illegal command flagging. Inputs change and outputs are sampled
//   1 time unit after the rising edge.
module tb_mig_ui_responder;
    localparam int AW = 29;
    localparam int DW = 256;
    localparam int MW = 32;
    localparam logic [2:0] WR = 3'b000;
    localparam logic [2:0] RD = 3'b001;

    logic ui_clk = 1'b0;
    logic ui_clk_sync_rst = 1'b1;
    logic init_calib_complete;
    logic cmd_err;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;

    logic [DW-1:0] rd_q[$];
    int unsigned   rd_cyc_q[$];

    mig_ui_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) app_if ();

    mig_ui_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .DEPTH_LOG2(6),
        .RD_LATENCY(4), .CALIB_CYCLES(16), .STALL_EVERY(3), .STALL_LEN(2)
    ) dut (
        .ui_clk              (ui_clk),
        .ui_clk_sync_rst     (ui_clk_sync_rst),
        .init_calib_complete (init_calib_complete),
        .cmd_err             (cmd_err),
        .app                 (app_if)
    );

    always #5 ui_clk = ~ui_clk;

    always @(posedge ui_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Read-return monitor: log every valid beat with the cycle it was seen.
    always @(posedge ui_clk) begin
        #1;
        if (app_if.app_rd_data_valid || app_if.app_rd_data_end) begin
            check_eq("rd_end", DW'(app_if.app_rd_data_end), DW'(app_if.app_rd_data_valid));
        end
        if (app_if.app_rd_data_valid) begin
            rd_q.push_back(app_if.app_rd_data);
            rd_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr, output int unsigned acc_cyc);
        int n = 0;
        app_if.app_cmd  = cmd;
        app_if.app_addr = addr;
        app_if.app_en   = 1'b1;
        while (!app_if.app_rdy && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_eq("cmd_rdy_timeout", DW'(app_if.app_rdy), DW'(1));
        acc_cyc = cyc;
        tick();
        app_if.app_en = 1'b0;
    endtask

    task automatic send_wdf(input logic [DW-1:0] data, input logic [MW-1:0] mask);
        int n = 0;
        app_if.app_wdf_data = data;
        app_if.app_wdf_mask = mask;
        app_if.app_wdf_wren = 1'b1;
        app_if.app_wdf_end  = 1'b1;
        while (!app_if.app_wdf_rdy && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_eq("wdf_rdy_timeout", DW'(app_if.app_wdf_rdy), DW'(1));
        tick();
        app_if.app_wdf_wren = 1'b0;
    endtask

    task automatic wait_rd(input int n);
        int k = 0;
        while (rd_q.size() < n && k < 60) begin
            tick();
            k++;
        end
    endtask

    int unsigned acc[10];
    int unsigned dummy;
    int unsigned exp_off[9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    logic [DW-1:0] exp_v;
    logic [DW-1:0] pat;

    initial begin
        app_if.app_addr     = '0;
        app_if.app_cmd      = 3'b000;
        app_if.app_en       = 1'b0;
        app_if.app_wdf_data = '0;
        app_if.app_wdf_mask = '0;
        app_if.app_wdf_wren = 1'b0;
        app_if.app_wdf_end  = 1'b0;

        // 1: reset values and calibration delay
        tick();
        tick();
        check_eq("rst_calib",  DW'(init_calib_complete), DW'(0));
        check_eq("rst_rdy",    DW'(app_if.app_rdy), DW'(0));
        check_eq("rst_wdfrdy", DW'(app_if.app_wdf_rdy), DW'(0));
        check_eq("rst_valid",  DW'(app_if.app_rd_data_valid), DW'(0));
        check_eq("rst_data",   app_if.app_rd_data, DW'(0));
        check_eq("rst_cmderr", DW'(cmd_err), DW'(0));
        ui_clk_sync_rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16) begin
                check_eq("calib_pre_rdy", DW'(app_if.app_rdy), DW'(0));
            end else begin
                check_eq("calib_rdy", DW'(app_if.app_rdy), DW'(1));
            end
            if (i == 15) check_eq("calib_15", DW'(init_calib_complete), DW'(0));
            if (i == 16) check_eq("calib_16", DW'(init_calib_complete), DW'(1));
        end

        // 4: throttle after every 3rd accept, no command lost
        rd_q.delete();
        rd_cyc_q.delete();
        for (int i = 0; i < 9; i++) send_cmd(RD, AW'(i * 8), acc[i % 10]);
        for (int i = 0; i < 9; i++) check_eq("stall_acc_off", DW'(acc[i] - acc[0]), DW'(exp_off[i]));
        wait_rd(9);
        check_eq("stall_rd_count", DW'(rd_q.size()), DW'(9));

        // 2: ten writes then ten reads, in order with fixed latency
        for (int i = 0; i < 10; i++) begin
            send_cmd(WR, AW'(i * 8), dummy);
            send_wdf(DW'(2 * (i + 1)), '0);
        end
        rd_q.delete();
        rd_cyc_q.delete();
        for (int i = 0; i < 10; i++) send_cmd(RD, AW'(i * 8), acc[i]);
        wait_rd(10);
        check_eq("seq_rd_count", DW'(rd_q.size()), DW'(10));
        for (int i = 0; i < 10 && i < rd_q.size(); i++) begin
            check_eq("seq_rd_data", rd_q[i], DW'(2 * (i + 1)));
            // executes the cycle after accept, then 4 cycles of pipe
            check_eq("seq_rd_lat", DW'(rd_cyc_q[i] - acc[i]), DW'(5));
        end

        // 3: byte mask over zeros
        send_cmd(WR, AW'(0), dummy);
        send_wdf('0, '0);
        send_cmd(WR, AW'(0), dummy);
        send_wdf({DW{1'b1}}, 32'h0000_000F);
        rd_q.delete();
        rd_cyc_q.delete();
        send_cmd(RD, AW'(0), dummy);
        // bits [2:0] and bits above the index are ignored: 525 aliases beat 1
        send_cmd(RD, AW'(525), dummy);
        wait_rd(2);
        exp_v = {DW{1'b1}};
        exp_v[31:0] = 32'h0;
        check_eq("mask_count", DW'(rd_q.size()), DW'(2));
        if (rd_q.size() >= 2) begin
            check_eq("mask_data", rd_q[0], exp_v);
            check_eq("alias_data", rd_q[1], DW'(4));
        end

        // 5: write command 5 cycles before its data, read queued behind
        rd_q.delete();
        rd_cyc_q.delete();
        pat = {8{32'hA5C3_0F96}};
        send_cmd(WR, AW'(16), acc[0]);
        send_cmd(RD, AW'(16), dummy);
        while (cyc < acc[0] + 5) tick();
        check_eq("raw_blocked", DW'(rd_q.size()), DW'(0));
        send_wdf(pat, '0);
        wait_rd(1);
        check_eq("raw_count", DW'(rd_q.size()), DW'(1));
        if (rd_q.size() >= 1) check_eq("raw_data", rd_q[0], pat);

        // 6: reset with reads in flight, then illegal command
        ui_clk_sync_rst = 1'b1;
        tick();
        ui_clk_sync_rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        for (int i = 0; i < 3; i++) send_cmd(RD, AW'(i * 8), dummy);
        ui_clk_sync_rst = 1'b1;
        #1;
        rd_q.delete();
        rd_cyc_q.delete();
        check_eq("rst_mid_valid", DW'(app_if.app_rd_data_valid), DW'(0));
        tick();
        tick();
        ui_clk_sync_rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("flush_no_valid", DW'(rd_q.size()), DW'(0));
        check_eq("cmderr_clear", DW'(cmd_err), DW'(0));
        send_cmd(3'b111, AW'(0), dummy);
        check_eq("cmderr_set", DW'(cmd_err), DW'(1));
        for (int i = 0; i < 10; i++) tick();
        check_eq("illegal_no_data", DW'(rd_q.size()), DW'(0));
        check_eq("cmderr_sticky", DW'(cmd_err), DW'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
